spi_master: RTL and testbench



---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_shift_reg.sv | 43 ++++
 rtl/spi_master.sv | 206 ++++++++++++++++++++
 tb/tb_spi_master.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: default frame geometry, FSM state
// encoding, opcode values and the common counter width.
package spi_pkg;

    localparam int unsigned CMD_W_DEF   = 10;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned RD_WAIT_DEF = 2;
    localparam int unsigned GAP_DEF     = 1;

    // Wide enough for every bit/wait/gap count used by the master.
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StCmd,
        StShift,
        StWait,
        StRecv,
        StGap
    } spi_state_e;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_reg.sv
// Parameterised MSB-first shift register with parallel load.
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset, clears the register
//   load_i   parallel load of data_i (has priority over shift_i)
//   data_i   parallel load value
//   shift_i  shift left by one, sin_i enters at bit 0
//   sin_i    serial input
//   q_o      current register contents
module spi_shift_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    input  logic             shift_i,
    input  logic             sin_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = data_i;
        end else if (shift_i) begin
            q_d = {q_q[Width-2:0], sin_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/spi_master.sv
// System-synchronous SPI master. Sends {op,payload} frames MSB-first on MOSI
// framed by SS_n, and for read-data frames captures the returned word on MISO.
// Ports:
//   clk, rst   clock (also SCK of the slave) and async active-high reset
//   start/cmd  frame request, accepted only while ready=1
//   ready      idle with inter-frame gap expired
//   done       1-cycle pulse on the first gap cycle of every frame
//   rd_data    last captured read word; rd_valid pulses with done for op 11
//   seq_err    pulses with done for an op 11 not preceded by an op 10
//   SS_n, MOSI, MISO  serial interface
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CMD_W   = CMD_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned RD_WAIT = RD_WAIT_DEF,
    parameter int unsigned GAP     = GAP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CMD_W-1:0]  cmd,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              seq_err,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    spi_state_e         state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [1:0]         op_q, op_d;
    logic               rd_addr_sent_q, rd_addr_sent_d;
    logic               ss_n_q, ss_n_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               rd_valid_q, rd_valid_d;
    logic               seq_err_q, seq_err_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;

    logic               tx_load, tx_shift, rx_shift, enter_gap;
    logic [CMD_W-1:0]   tx_q;
    logic [DATA_W-1:0]  rx_q;

    // TX register MSB is MOSI directly: loaded on accept, held through START and
    // CMD, shifted after each SHIFT bit so it drains to zero by the end of SHIFT.
    spi_shift_reg #(.Width(CMD_W)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tx_load),
        .data_i  (cmd),
        .shift_i (tx_shift),
        .sin_i   (1'b0),
        .q_o     (tx_q)
    );

    spi_shift_reg #(.Width(DATA_W)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .load_i  (1'b0),
        .data_i  ('0),
        .shift_i (rx_shift),
        .sin_i   (MISO),
        .q_o     (rx_q)
    );

    // Only the TX MSB leaves the register; the RX MSB is superseded by the
    // final MISO sample when rd_data is loaded.
    logic unused_bits;
    assign unused_bits = ^{tx_q[CMD_W-2:0], rx_q[DATA_W-1]};

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        op_d           = op_q;
        rd_addr_sent_d = rd_addr_sent_q;
        rd_data_d      = rd_data_q;
        done_d         = 1'b0;
        rd_valid_d     = 1'b0;
        seq_err_d      = 1'b0;
        tx_load        = 1'b0;
        tx_shift       = 1'b0;
        rx_shift       = 1'b0;
        enter_gap      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gap_cnt_q < CNT_W'(GAP)) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
                if (start && ready_q) begin
                    tx_load   = 1'b1;
                    op_d      = cmd[CMD_W-1 -: 2];
                    gap_cnt_d = '0;
                    state_d   = StStart;
                end
            end
            StStart: state_d = StCmd;
            StCmd: begin
                bit_cnt_d = '0;
                state_d   = StShift;
            end
            StShift: begin
                tx_shift = 1'b1;
                if (bit_cnt_q >= CNT_W'(CMD_W - 1)) begin
                    if (op_q == OP_RD_DATA) begin
                        wait_cnt_d = '0;
                        state_d    = StWait;
                    end else begin
                        enter_gap = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StWait: begin
                if (wait_cnt_q >= CNT_W'(RD_WAIT - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = StRecv;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StRecv: begin
                rx_shift = 1'b1;
                if (bit_cnt_q >= CNT_W'(DATA_W - 1)) begin
                    rd_data_d = {rx_q[DATA_W-2:0], MISO};
                    enter_gap = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_cnt_q >= CNT_W'(GAP)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Frame completion: the first gap cycle already counts toward GAP.
        if (enter_gap) begin
            state_d    = StGap;
            gap_cnt_d  = CNT_W'(1);
            done_d     = 1'b1;
            rd_valid_d = (op_q == OP_RD_DATA);
            seq_err_d  = (op_q == OP_RD_DATA) && !rd_addr_sent_q;
            if (op_q == OP_RD_ADDR) begin
                rd_addr_sent_d = 1'b1;
            end else if (op_q == OP_RD_DATA) begin
                rd_addr_sent_d = 1'b0;
            end
        end

        ss_n_d  = (state_d == StIdle) || (state_d == StGap);
        ready_d = (state_d == StIdle) && (gap_cnt_d >= CNT_W'(GAP));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            bit_cnt_q      <= '0;
            wait_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            op_q           <= '0;
            rd_addr_sent_q <= 1'b0;
            ss_n_q         <= 1'b1;
            ready_q        <= 1'b0;
            done_q         <= 1'b0;
            rd_valid_q     <= 1'b0;
            seq_err_q      <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            op_q           <= op_d;
            rd_addr_sent_q <= rd_addr_sent_d;
            ss_n_q         <= ss_n_d;
            ready_q        <= ready_d;
            done_q         <= done_d;
            rd_valid_q     <= rd_valid_d;
            seq_err_q      <= seq_err_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign SS_n     = ss_n_q;
    assign MOSI     = tx_q[CMD_W-1];
    assign ready    = ready_q;
    assign done     = done_q;
    assign rd_valid = rd_valid_q;
    assign seq_err  = seq_err_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: a driver issues frames and pushes the
// expected outcome from a reference model; a slave model drives MISO from a
// RAM built out of the decoded MOSI frames; a monitor checks every done.
module tb_spi_master;

    localparam int CmdW     = 10;
    localparam int DataW    = 8;
    localparam int RdWait   = 2;
    localparam int GapCyc   = 1;
    localparam int PreBits  = 2;                       // START + CMD cycles
    localparam int WrLen    = PreBits + CmdW;          // SS_n-low length, no read-back
    localparam int RxFirst  = WrLen + RdWait + 1;      // first MISO bit cycle in frame
    localparam int RxLast   = RxFirst + DataW - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CmdW-1:0]  cmd = '0;
    logic             ready, done, rd_valid, seq_err, ss_n, mosi;
    logic [DataW-1:0] rd_data;
    logic             miso = 1'b0;

    spi_master #(
        .CMD_W   (CmdW),
        .DATA_W  (DataW),
        .RD_WAIT (RdWait),
        .GAP     (GapCyc)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmd      (cmd),
        .ready    (ready),
        .done     (done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .seq_err  (seq_err),
        .SS_n     (ss_n),
        .MOSI     (mosi),
        .MISO     (miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [9:0] cmd;
        int         len;
        logic       rv;
        logic       se;
        logic [7:0] rd;
        int         acc_cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_ram [256];
    logic [7:0] ref_wa = '0, ref_ra = '0, ref_rd = '0;
    logic       ref_sent = 1'b0;

    task automatic model_push(input logic [9:0] c);
        exp_t       e;
        logic [1:0] op;
        logic [7:0] p;
        op = c[9:8];
        p  = c[7:0];
        e.cmd = c;
        e.rv  = 1'b0;
        e.se  = 1'b0;
        e.len = WrLen;
        case (op)
            2'b00: ref_wa = p;
            2'b01: ref_ram[ref_wa] = p;
            2'b10: begin ref_ra = p; ref_sent = 1'b1; end
            default: begin
                e.rv     = 1'b1;
                e.se     = !ref_sent;
                ref_rd   = ref_ram[ref_ra];
                ref_sent = 1'b0;
                e.len    = WrLen + RdWait + DataW;
            end
        endcase
        e.rd      = ref_rd;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
    endtask

    // ---------------- slave / RAM model ----------------
    int         scnt = 0;
    logic [9:0] sframe = '0;
    logic [7:0] s_ram [256];
    logic [7:0] s_wa = '0, s_ra = '0, s_word = '0;

    always @(negedge clk) begin
        if (ss_n) begin
            scnt = 0;
            miso = 1'b0;
        end else begin
            scnt++;
            if (scnt > PreBits && scnt <= WrLen) sframe = {sframe[8:0], mosi};
            if (scnt == WrLen) begin
                case (sframe[9:8])
                    2'b00:   s_wa = sframe[7:0];
                    2'b01:   s_ram[s_wa] = sframe[7:0];
                    2'b10:   s_ra = sframe[7:0];
                    default: s_word = s_ram[s_ra];
                endcase
            end
            miso = (scnt >= RxFirst && scnt <= RxLast) ? s_word[3'(RxLast - scnt)] : 1'b0;
        end
    end

    // ---------------- monitor ----------------
    int         mcnt = 0, last_len = 0, bad = 0;
    logic       stream [64];
    logic       last_stream [64];
    logic [9:0] got_frame;
    logic       exp_bit;
    exp_t       me;

    always @(negedge clk) begin
        if (!ss_n) begin
            if (mcnt < 64) stream[mcnt] = mosi;
            mcnt++;
        end else begin
            if (mcnt != 0) begin
                last_len    = mcnt;
                last_stream = stream;
                mcnt        = 0;
            end
            check("mosi_idle", 32'(mosi), 32'd0);
        end
        if ((rd_valid || seq_err) && !done) check("pulse_without_done", {rd_valid, seq_err}, 0);
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                me = exp_q.pop_front();
                check("ss_low_len", last_len, me.len);
                check("start_to_done", cyc - me.acc_cyc, me.len + 1);
                for (int j = 0; j < CmdW; j++) got_frame[CmdW-1-j] = last_stream[PreBits+j];
                check("mosi_frame", got_frame, me.cmd);
                bad = 0;
                for (int i = 0; i < me.len && i < 64; i++) begin
                    if (i < PreBits)     exp_bit = me.cmd[9];
                    else if (i < WrLen)  exp_bit = me.cmd[WrLen-1-i];
                    else                 exp_bit = 1'b0;
                    if (last_stream[i] !== exp_bit) bad++;
                end
                check("mosi_stream_bad_bits", bad, 0);
                check("rd_valid", 32'(rd_valid), 32'(me.rv));
                check("seq_err", 32'(seq_err), 32'(me.se));
                check("rd_data", 32'(rd_data), 32'(me.rd));
                check("ready_in_gap", 32'(ready), 32'd0);
                last_len = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [9:0] c, input bit push);
        int w;
        w = 0;
        @(negedge clk);
        while (!ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", 32'(ready), 32'd1);
        if (ready) begin
            start = 1'b1;
            cmd   = c;
            if (push) model_push(c);
            @(posedge clk);
            #1;
            start = 1'b0;
            cmd   = 10'($urandom);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("all_frames_done", exp_q.size(), 0);
    endtask

    logic [1:0] rop;
    logic [7:0] rpay;

    initial begin
        for (int a = 0; a < 256; a++) begin
            ref_ram[a] = '0;
            s_ram[a]   = '0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ss_n", 32'(ss_n), 32'd1);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_seq_err", 32'(seq_err), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_gap", 32'(ready), 32'd1);

        // Read-data with no prior read-address, then a proper read pair
        send(10'h300, 1'b1);
        send(10'h201, 1'b1);
        send(10'h300, 1'b1);
        // Write address, full write, read back
        send(10'h03C, 1'b1);
        send(10'h005, 1'b1);
        send(10'h1A5, 1'b1);
        send(10'h205, 1'b1);
        send(10'h300, 1'b1);

        // start while busy must be ignored
        send(10'h207, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        cmd   = 10'h1FF;
        @(negedge clk);
        start = 1'b0;

        // Randomised traffic on a small address window so reads hit writes
        for (int k = 0; k < 30; k++) begin
            rop  = 2'($urandom_range(0, 3));
            rpay = (rop[0] == 1'b0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            send({rop, rpay}, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Load a non-zero rd_data, then reset in the middle of SHIFT
        send(10'h009, 1'b1);
        send(10'h15A, 1'b1);
        send(10'h209, 1'b1);
        send(10'h300, 1'b1);
        drain();
        send(10'h077, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ss_n", 32'(ss_n), 32'd1);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        check("midrst_mosi", 32'(mosi), 32'd0);
        @(negedge clk);
        check("midrst_done", 32'(done), 32'd0);
        ref_rd   = '0;
        ref_sent = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Flag cleared by reset: read-data errors, then a clean pair
        send(10'h300, 1'b1);
        send(10'h209, 1'b1);
        send(10'h300, 1'b1);
        drain();

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
